// File: rtl/kd_seq_pkg.sv
// kd_seq_pkg: Run_mode codes, sequencer state encoding and the
// (scheme, direction, phase) -> Run_mode lookup shared by the sequencer.
package kd_seq_pkg;

   localparam int unsigned RM_W = 4;

   localparam logic [RM_W-1:0] RM_IDLE         = 4'd0;
   localparam logic [RM_W-1:0] RM_K2_NTT       = 4'd1;
   localparam logic [RM_W-1:0] RM_K2_NTT_DONE  = 4'd2;
   localparam logic [RM_W-1:0] RM_K4_NTT       = 4'd3;
   localparam logic [RM_W-1:0] RM_K4_NTT_DONE  = 4'd4;
   localparam logic [RM_W-1:0] RM_D2_NTT       = 4'd5;
   localparam logic [RM_W-1:0] RM_D2_NTT_DONE  = 4'd6;
   localparam logic [RM_W-1:0] RM_K2_INTT      = 4'd7;
   localparam logic [RM_W-1:0] RM_K2_INTT_DONE = 4'd8;
   localparam logic [RM_W-1:0] RM_K4_INTT      = 4'd9;
   localparam logic [RM_W-1:0] RM_K4_INTT_DONE = 4'd10;
   localparam logic [RM_W-1:0] RM_D2_INTT      = 4'd11;
   localparam logic [RM_W-1:0] RM_D2_INTT_DONE = 4'd12;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_COMP0  = 3'd1,
      ST_DRAIN0 = 3'd2,
      ST_COMP1  = 3'd3,
      ST_DRAIN1 = 3'd4
   } seq_state_e;

   // Run_mode for a given phase position; positions past the end of a
   // Dilithium sequence map to RM_IDLE.
   function automatic logic [RM_W-1:0] seq_code(input logic       kd_sel,
                                                input logic       op_inv,
                                                input logic [1:0] phase_idx);
      logic [RM_W-1:0] code;
      code = RM_IDLE;
      case ({kd_sel, op_inv})
         2'b00: begin
            case (phase_idx)
               2'd0:    code = RM_K2_NTT;
               2'd1:    code = RM_K2_NTT_DONE;
               2'd2:    code = RM_K4_NTT;
               default: code = RM_K4_NTT_DONE;
            endcase
         end
         2'b01: begin
            case (phase_idx)
               2'd0:    code = RM_K4_INTT;
               2'd1:    code = RM_K4_INTT_DONE;
               2'd2:    code = RM_K2_INTT;
               default: code = RM_K2_INTT_DONE;
            endcase
         end
         2'b10: begin
            case (phase_idx)
               2'd0:    code = RM_D2_NTT;
               2'd1:    code = RM_D2_NTT_DONE;
               default: code = RM_IDLE;
            endcase
         end
         default: begin
            case (phase_idx)
               2'd0:    code = RM_D2_INTT;
               2'd1:    code = RM_D2_INTT_DONE;
               default: code = RM_IDLE;
            endcase
         end
      endcase
      return code;
   endfunction

endpackage

// File: rtl/kd_phase_timer.sv
// kd_phase_timer: per-phase cycle counter, stale-flag guard and watchdog.
// Optional watchdog compiled in with KD_SEQ_TIMEOUT_EN.
module kd_phase_timer #(
`ifdef KD_SEQ_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC = 2047,
`endif
   parameter int unsigned CNT_W       = 12
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_run,
   input  logic       i_clr,
   input  logic       i_drain,
   input  logic [1:0] i_done_flag,
   output logic       o_adv_c,
   output logic       o_timeout_c
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] r_cnt;
   logic             w_flag;

   // Only the flag belonging to the current phase type counts.
   assign w_flag  = i_drain ? i_done_flag[1] : i_done_flag[0];
   // First cycle of a phase (count 0) ignores flags left high from before.
   assign o_adv_c = i_run && (r_cnt != '0) && w_flag;

`ifdef KD_SEQ_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);
   assign o_timeout_c = i_run && !o_adv_c && (r_cnt == TO_CNT);
`else
   assign o_timeout_c = 1'b0;
`endif

   // Phase counter: cleared on any phase/state change, saturates at max.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || !i_run) begin
         r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/kd_run_sequencer.sv
// kd_run_sequencer: turns one start command into the ordered Run_mode /
// KD_mode phase sequence for KD_top, advancing on the done_flag handshake.
// Optional per-phase watchdog compiled in with KD_SEQ_TIMEOUT_EN.
module kd_run_sequencer
   import kd_seq_pkg::*;
#(
`ifdef KD_SEQ_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYC = 2047,
`endif
   parameter int unsigned CNT_W       = 12,
   parameter int unsigned TOT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_inv,
   input  logic             kd_sel,
   input  logic             abort,
   input  logic [1:0]       done_flag,
   output logic [RM_W-1:0]  Run_mode,
   output logic             KD_mode,
   output logic             busy,
   output logic             seq_done,
   output logic             err,
   output logic [TOT_W-1:0] cyc_total
);

   localparam logic [TOT_W-1:0] TOT_MAX = '1;

   seq_state_e       r_state, w_nxt_state;
   logic [RM_W-1:0]  r_run_mode, w_nxt_rm;
   logic             r_kd_mode, w_nxt_kd;
   logic             r_inv, w_nxt_inv;
   logic             r_busy, w_nxt_busy;
   logic             r_seq_done, w_nxt_done;
   logic             r_err, w_nxt_err;
   logic [TOT_W-1:0] r_tot, w_nxt_tot;
   logic             w_fin;
   logic             w_adv, w_timeout, w_clr, w_drain;

   assign w_drain = (r_state == ST_DRAIN0) || (r_state == ST_DRAIN1);
   assign w_clr   = (w_nxt_state != r_state);

   kd_phase_timer #(
`ifdef KD_SEQ_TIMEOUT_EN
      .TIMEOUT_CYC (TIMEOUT_CYC),
`endif
      .CNT_W       (CNT_W)
   ) u_timer (
      .i_clk       (clk),
      .i_rst_n     (rst),
      .i_run       (r_busy),
      .i_clr       (w_clr),
      .i_drain     (w_drain),
      .i_done_flag (done_flag),
      .o_adv_c     (w_adv),
      .o_timeout_c (w_timeout)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_rm    = r_run_mode;
      w_nxt_kd    = r_kd_mode;
      w_nxt_inv   = r_inv;
      w_nxt_busy  = r_busy;
      w_nxt_done  = 1'b0;
      w_nxt_err   = r_err;
      w_nxt_tot   = (r_busy && (r_tot != TOT_MAX)) ? r_tot + TOT_W'(1) : r_tot;
      w_fin       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_nxt_state = ST_COMP0;
               w_nxt_rm    = seq_code(kd_sel, op_inv, 2'd0);
               w_nxt_kd    = kd_sel;
               w_nxt_inv   = op_inv;
               w_nxt_busy  = 1'b1;
               w_nxt_err   = 1'b0;
               w_nxt_tot   = '0;
            end
         end
         ST_COMP0, ST_DRAIN0, ST_COMP1, ST_DRAIN1: begin
            if (abort) begin
               w_nxt_state = ST_IDLE;
               w_nxt_rm    = RM_IDLE;
               w_nxt_busy  = 1'b0;
            end else if (w_timeout) begin
               w_nxt_state = ST_IDLE;
               w_nxt_rm    = RM_IDLE;
               w_nxt_busy  = 1'b0;
               w_nxt_err   = 1'b1;
            end else if (w_adv) begin
               case (r_state)
                  ST_COMP0: begin
                     w_nxt_state = ST_DRAIN0;
                     w_nxt_rm    = seq_code(r_kd_mode, r_inv, 2'd1);
                  end
                  ST_DRAIN0: begin
                     if (r_kd_mode) begin
                        w_fin = 1'b1;
                     end else begin
                        w_nxt_state = ST_COMP1;
                        w_nxt_rm    = seq_code(r_kd_mode, r_inv, 2'd2);
                     end
                  end
                  ST_COMP1: begin
                     w_nxt_state = ST_DRAIN1;
                     w_nxt_rm    = seq_code(r_kd_mode, r_inv, 2'd3);
                  end
                  default: w_fin = 1'b1;
               endcase
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_rm    = RM_IDLE;
            w_nxt_busy  = 1'b0;
         end
      endcase

      if (w_fin) begin
         w_nxt_state = ST_IDLE;
         w_nxt_rm    = RM_IDLE;
         w_nxt_busy  = 1'b0;
         w_nxt_done  = 1'b1;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_run_mode <= RM_IDLE;
         r_kd_mode  <= 1'b0;
         r_inv      <= 1'b0;
         r_busy     <= 1'b0;
         r_seq_done <= 1'b0;
         r_err      <= 1'b0;
         r_tot      <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_run_mode <= w_nxt_rm;
         r_kd_mode  <= w_nxt_kd;
         r_inv      <= w_nxt_inv;
         r_busy     <= w_nxt_busy;
         r_seq_done <= w_nxt_done;
         r_err      <= w_nxt_err;
         r_tot      <= w_nxt_tot;
      end
   end

   assign Run_mode  = r_run_mode;
   assign KD_mode   = r_kd_mode;
   assign busy      = r_busy;
   assign seq_done  = r_seq_done;
   assign err       = r_err;
   assign cyc_total = r_tot;

endmodule

// File: tb/tb_kd_run_sequencer.sv
// tb_kd_run_sequencer: directed vectors for kd_run_sequencer.
// Watchdog section follows KD_SEQ_TIMEOUT_EN.
module tb_kd_run_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        op_inv;
   logic        kd_sel;
   logic        abort;
   logic [1:0]  done_flag;
   logic [3:0]  Run_mode;
   logic        KD_mode;
   logic        busy;
   logic        seq_done;
   logic        err;
   logic [15:0] cyc_total;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   kd_run_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_inv    (op_inv),
      .kd_sel    (kd_sel),
      .abort     (abort),
      .done_flag (done_flag),
      .Run_mode  (Run_mode),
      .KD_mode   (KD_mode),
      .busy      (busy),
      .seq_done  (seq_done),
      .err       (err),
      .cyc_total (cyc_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a start and check the first-cycle state.
   task automatic do_start(input string tag, input logic kd, input logic inv, input logic [3:0] code);
      start  = 1'b1;
      kd_sel = kd;
      op_inv = inv;
      tick();
      start  = 1'b0;
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rm0"}, Run_mode, code);
      chk({tag, "_kd"}, KD_mode, kd);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_tot0"}, cyc_total, 0);
   endtask

   // Check current phase code, then answer with the phase's flag after dly cycles.
   task automatic run_phase(input string tag, input logic [3:0] code, input bit drain,
                            input int dly, input logic kd);
      chk({tag, "_rm"}, Run_mode, code);
      chk({tag, "_kdh"}, KD_mode, kd);
      chk({tag, "_sd"}, seq_done, 0);
      repeat (dly) tick();
      done_flag = drain ? 2'b10 : 2'b01;
      tick();
      done_flag = 2'b00;
   endtask

   // Completion cycle and the cycle after it.
   task automatic check_end(input string tag, input logic kd, input int unsigned tot);
      chk({tag, "_rm_end"}, Run_mode, 0);
      chk({tag, "_busy_end"}, busy, 0);
      chk({tag, "_sd_pulse"}, seq_done, 1);
      chk({tag, "_tot"}, cyc_total, tot);
      tick();
      chk({tag, "_sd_low"}, seq_done, 0);
      chk({tag, "_tot_hold"}, cyc_total, tot);
      chk({tag, "_kd_hold"}, KD_mode, kd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; start = 1'b0; op_inv = 1'b0; kd_sel = 1'b0;
      abort = 1'b0; done_flag = 2'b00;
      #3;
      chk("rst_rm", Run_mode, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sd", seq_done, 0);
      chk("rst_err", err, 0);
      chk("rst_tot", cyc_total, 0);
      chk("rst_kd", KD_mode, 0);
      #19 rst = 1'b1;
      tick();

      // Kyber NTT: 33+18+33+18 busy cycles
      do_start("kntt", 1'b0, 1'b0, 4'd1);
      run_phase("kntt_p0", 4'd1, 1'b0, 32, 1'b0);
      run_phase("kntt_p1", 4'd2, 1'b1, 17, 1'b0);
      run_phase("kntt_p2", 4'd3, 1'b0, 32, 1'b0);
      run_phase("kntt_p3", 4'd4, 1'b1, 17, 1'b0);
      check_end("kntt", 1'b0, 102);

      // Kyber INTT: 5+3+7+4
      do_start("kintt", 1'b0, 1'b1, 4'd9);
      run_phase("kintt_p0", 4'd9,  1'b0, 4, 1'b0);
      run_phase("kintt_p1", 4'd10, 1'b1, 2, 1'b0);
      run_phase("kintt_p2", 4'd7,  1'b0, 6, 1'b0);
      run_phase("kintt_p3", 4'd8,  1'b1, 3, 1'b0);
      check_end("kintt", 1'b0, 19);

      // Dilithium NTT: 6+4
      do_start("dntt", 1'b1, 1'b0, 4'd5);
      run_phase("dntt_p0", 4'd5, 1'b0, 5, 1'b1);
      run_phase("dntt_p1", 4'd6, 1'b1, 3, 1'b1);
      check_end("dntt", 1'b1, 10);

      // Dilithium INTT: minimum legal answer delay, 2+2
      do_start("dintt", 1'b1, 1'b1, 4'd11);
      run_phase("dintt_p0", 4'd11, 1'b0, 1, 1'b1);
      run_phase("dintt_p1", 4'd12, 1'b1, 1, 1'b1);
      check_end("dintt", 1'b1, 4);

      // Both flags stuck high: two cycles per phase, start ignored while busy
      done_flag = 2'b11;
      do_start("stale", 1'b0, 1'b0, 4'd1);
      start = 1'b1; kd_sel = 1'b1; op_inv = 1'b1;
      tick(); tick();
      chk("stale_rm2", Run_mode, 2);
      chk("stale_kd_ign", KD_mode, 0);
      start = 1'b0; kd_sel = 1'b0; op_inv = 1'b0;
      tick(); tick();
      chk("stale_rm3", Run_mode, 3);
      tick(); tick();
      chk("stale_rm4", Run_mode, 4);
      tick(); tick();
      check_end("stale", 1'b0, 8);
      done_flag = 2'b00;

      // Abort in COMP1: 4+4 phase cycles plus 3 in COMP1
      do_start("abrt", 1'b0, 1'b0, 4'd1);
      run_phase("abrt_p0", 4'd1, 1'b0, 3, 1'b0);
      run_phase("abrt_p1", 4'd2, 1'b1, 3, 1'b0);
      chk("abrt_in_comp1", Run_mode, 3);
      tick(); tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abrt_rm", Run_mode, 0);
      chk("abrt_busy", busy, 0);
      chk("abrt_sd", seq_done, 0);
      chk("abrt_tot", cyc_total, 11);
      tick();
      chk("abrt_sd_after", seq_done, 0);

      // Abort with start in IDLE: nothing happens
      start = 1'b1; abort = 1'b1; kd_sel = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0; kd_sel = 1'b0;
      chk("idle_abrt_busy", busy, 0);
      chk("idle_abrt_rm", Run_mode, 0);
      chk("idle_abrt_kd", KD_mode, 0);
      chk("idle_abrt_tot", cyc_total, 11);

`ifdef KD_SEQ_TIMEOUT_EN
      // Watchdog: counter reaches 2047 after 2047 edges, trips on the next
      do_start("wdog", 1'b0, 1'b0, 4'd1);
      repeat (2047) @(posedge clk);
      #1;
      chk("wdog_busy_pre", busy, 1);
      chk("wdog_err_pre", err, 0);
      tick();
      chk("wdog_err", err, 1);
      chk("wdog_busy", busy, 0);
      chk("wdog_rm", Run_mode, 0);
      chk("wdog_sd", seq_done, 0);
      chk("wdog_tot", cyc_total, 2048);
      tick();
      chk("wdog_err_sticky", err, 1);
      do_start("wdog_clr", 1'b1, 1'b1, 4'd11);
      abort = 1'b1;
      tick();
      abort = 1'b0;
`else
      // No watchdog: still waiting after 5000 cycles
      do_start("nowd", 1'b0, 1'b0, 4'd1);
      repeat (5000) @(posedge clk);
      #1;
      chk("nowd_busy", busy, 1);
      chk("nowd_rm", Run_mode, 1);
      chk("nowd_err", err, 0);
      chk("nowd_tot", cyc_total, 5000);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("nowd_abrt", busy, 0);
`endif

      // Async reset in DRAIN0, between edges
      do_start("arst", 1'b1, 1'b0, 4'd5);
      run_phase("arst_p0", 4'd5, 1'b0, 2, 1'b1);
      chk("arst_in_drain0", Run_mode, 6);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_rm", Run_mode, 0);
      chk("arst_busy", busy, 0);
      chk("arst_kd", KD_mode, 0);
      chk("arst_tot", cyc_total, 0);
      chk("arst_err", err, 0);
      chk("arst_sd", seq_done, 0);
      tick();
      rst = 1'b1;
      tick();
      do_start("post", 1'b1, 1'b1, 4'd11);
      run_phase("post_p0", 4'd11, 1'b0, 2, 1'b1);
      run_phase("post_p1", 4'd12, 1'b1, 2, 1'b1);
      check_end("post", 1'b1, 6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
